// File: rtl/vm_pkg.sv
// vm_pkg: shared state encodings, coin codes and coin values for the vending controller
package vm_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_VEND    = 2'd2;
    localparam state_t ST_CHANGE  = 2'd3;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_05   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_50   = 2'b11;
    localparam int VAL_05 = 1;
    localparam int VAL_10 = 2;
    localparam int VAL_50 = 10;
endpackage

// File: rtl/vm_change_ctr.sv
// vm_change_ctr: loadable down-counter that strobes the change hopper once per unit while enabled
module vm_change_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         pulse,
    output logic         last
);
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (en && count != '0) count <= count - W'(1);
    end
    assign pulse = en && count != '0;
    assign last  = count <= W'(1);
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised coin controller with cancel/refund, coin rejection and serial change
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 5,
    parameter int COIN5_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                sell,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);
    localparam int SW = CREDIT_W + 1;
    localparam logic [CREDIT_W:0] PRICE_S = SW'(PRICE);
    localparam logic [CREDIT_W:0] MAX_S   = SW'(MAX_CREDIT);
    if (MAX_CREDIT >= 2**CREDIT_W || PRICE < 1 || PRICE > MAX_CREDIT) begin : g_bad_params
        $error("vending_machine_param: illegal PRICE/MAX_CREDIT/CREDIT_W combination");
    end
    state_t              st;
    logic [CREDIT_W:0]   v, sum;
    logic [CREDIT_W-1:0] refund, load_val;
    logic                cancel_go, take, vend_go, load, last;
    always_comb begin
        v = coin == COIN_05 ? SW'(VAL_05) :
            coin == COIN_10 ? SW'(VAL_10) :
            (coin == COIN_50 && COIN5_EN != 0) ? SW'(VAL_50) : '0;
        sum       = {1'b0, credit} + v;
        cancel_go = st == ST_COLLECT && cancel;
        // any coin that is not taken here goes back through the acceptor
        take      = (st == ST_IDLE || st == ST_COLLECT) && !cancel_go && v != '0 && sum <= MAX_S;
        vend_go   = take && sum >= PRICE_S;
        load      = vend_go || cancel_go;
        load_val  = cancel_go ? credit : CREDIT_W'(sum - PRICE_S);
    end
    vm_change_ctr #(.W(CREDIT_W)) u_change (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (st == ST_CHANGE),
        .value(load_val),
        .count(refund),
        .pulse(change_pulse),
        .last (last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin != COIN_NONE && !take;
            case (st)
                ST_IDLE, ST_COLLECT: begin
                    if (cancel_go || vend_go) begin
                        credit <= '0;
                        st     <= cancel_go ? ST_CHANGE : ST_VEND;
                    end else if (take) begin
                        credit <= sum[CREDIT_W-1:0];
                        st     <= ST_COLLECT;
                    end
                end
                ST_VEND: begin
                    credit <= '0;
                    st     <= refund != '0 ? ST_CHANGE : ST_IDLE;
                end
                ST_CHANGE: st <= last ? ST_IDLE : ST_CHANGE;
                default: begin
                    credit <= '0;
                    st     <= ST_IDLE;
                end
            endcase
        end
    end
    assign sell = st == ST_VEND;
    assign busy = st == ST_VEND || st == ST_CHANGE;
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: three parameter variants driven in lockstep against a unit-level reference model
module tb_vending_machine_param;
    typedef struct packed {
        logic       sell;
        logic       chg;
        logic       rej;
        logic       busy;
        logic [4:0] credit;
    } obs_t;
    typedef obs_t [2:0] trio_t;
    localparam int PR [3] = '{3, 15, 3};
    localparam int C5 [3] = '{1, 1, 0};
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic [2:0] sell, chg, rej, busy;
    logic [4:0] credit [3];
    trio_t      q [$];
    int         checks = 0;
    int         errors = 0;
    int         m_credit [3];
    int         m_chg [3];
    bit         m_vend [3];
    always #5 clk = ~clk;
    vending_machine_param u_def (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .sell(sell[0]),
        .change_pulse(chg[0]), .coin_reject(rej[0]), .busy(busy[0]), .credit(credit[0])
    );
    vending_machine_param #(.PRICE(15)) u_p15 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .sell(sell[1]),
        .change_pulse(chg[1]), .coin_reject(rej[1]), .busy(busy[1]), .credit(credit[1])
    );
    vending_machine_param #(.COIN5_EN(0)) u_c0 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .sell(sell[2]),
        .change_pulse(chg[2]), .coin_reject(rej[2]), .busy(busy[2]), .credit(credit[2])
    );
    // Model: credit held, a pending vend, and units of change still owed
    function automatic obs_t model(int i, logic [1:0] c, logic can, logic r);
        obs_t o;
        int   v;
        v = c == 2'd1 ? 1 : c == 2'd2 ? 2 : (c == 2'd3 && C5[i] != 0) ? 10 : 0;
        o.rej = 1'b0;
        if (r) begin
            m_credit[i] = 0;
            m_vend[i]   = 0;
            m_chg[i]    = 0;
        end else if (m_vend[i] || m_chg[i] > 0) begin
            o.rej = c != 2'd0;
            if (m_vend[i]) m_vend[i] = 0;
            else m_chg[i] = m_chg[i] - 1;
        end else if (can && m_credit[i] > 0) begin
            m_chg[i]    = m_credit[i];
            m_credit[i] = 0;
            o.rej       = c != 2'd0;
        end else if (c != 2'd0) begin
            if (v == 0 || m_credit[i] + v > 20) o.rej = 1'b1;
            else if (m_credit[i] + v >= PR[i]) begin
                m_vend[i]   = 1;
                m_chg[i]    = m_credit[i] + v - PR[i];
                m_credit[i] = 0;
            end else m_credit[i] = m_credit[i] + v;
        end
        o.sell   = m_vend[i];
        o.chg    = !m_vend[i] && m_chg[i] > 0;
        o.busy   = m_vend[i] || m_chg[i] > 0;
        o.credit = 5'(m_credit[i]);
        return o;
    endfunction
    task automatic step(logic [1:0] c, logic can, logic r);
        trio_t e;
        @(negedge clk);
        coin   = c;
        cancel = can;
        rst    = r;
        for (int i = 0; i < 3; i++) e[i] = model(i, c, can, r);
        q.push_back(e);
    endtask
    initial forever begin
        trio_t e;
        obs_t  a;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            for (int i = 0; i < 3; i++) begin
                a = {sell[i], chg[i], rej[i], busy[i], credit[i]};
                checks++;
                if (a !== e[i]) begin
                    errors++;
                    $display("FAIL dut%0d t=%0t got sell=%b chg=%b rej=%b busy=%b credit=%0d want sell=%b chg=%b rej=%b busy=%b credit=%0d",
                             i, $time, a.sell, a.chg, a.rej, a.busy, a.credit,
                             e[i].sell, e[i].chg, e[i].rej, e[i].busy, e[i].credit);
                end
            end
        end
    end
    // Directed codes: bits[1:0] coin, bit2 cancel, bit3 reset
    int dir [$] = '{8, 8,
                    1, 1, 1, 0, 0,
                    2, 2, 0, 0, 0,
                    3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 4, 0, 0, 4, 0,
                    8, 3, 2, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    3, 0, 0, 0, 8, 0, 1, 0, 0};
    initial begin
        int d;
        for (int k = 0; k < dir.size(); k++) begin
            d = dir[k];
            step(d[1:0], d[2], d[3]);
        end
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) c = 2'd0;
            step(c, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (3) step(2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
